// File: rtl/bus_master_port.sv
// Master-side initiator for the shared serial system bus.
// Requests the bus, shifts out address/write data, or collects read data.
module bus_master_port #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              breq,
    input  logic              bgrant,
    output logic              mout,
    output logic              mvalid,
    output logic              mmode,
    input  logic              sin,
    input  logic              svalid
);

    localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAXV   = (MAX_AD > TIMEOUT) ? MAX_AD : TIMEOUT;
    localparam int CW     = $clog2(MAXV + 1);

    localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_tmo;
    logic              r_wr;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_rdata;
    logic              w_abit;
    logic              w_dbit;
    logic              w_shifting;

    assign w_abit = |(r_addr & (ADDR_W'(1) << r_cnt));
    assign w_dbit = |(r_wdata & (DATA_W'(1) << r_cnt));
    assign w_shifting = (r_state == S_ADDR) || (r_state == S_WDATA);

    // Grant loss gates the serial outputs in the same cycle.
    assign mvalid = w_shifting && bgrant;
    assign mout   = mvalid && ((r_state == S_ADDR) ? w_abit : w_dbit);
    assign mmode  = mvalid && r_wr;
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign err    = done && r_err;
    assign rdata  = r_rdata;
    assign breq   = (r_state == S_REQ) || w_shifting || (r_state == S_RDATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req) w_next = S_REQ;
            end
            S_REQ: begin
                if (bgrant) w_next = S_ADDR;
            end
            S_ADDR: begin
                if (!bgrant) w_next = S_REQ;
                else if (r_cnt == A_LAST) w_next = r_wr ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                if (!bgrant) w_next = S_REQ;
                else if (r_cnt == D_LAST) w_next = S_DONE;
            end
            S_RDATA: begin
                if (!bgrant) w_next = S_REQ;
                else if (svalid && r_cnt == D_LAST) w_next = S_DONE;
                else if (!svalid && r_cnt == '0 && r_tmo == T_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_shift <= '0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_wr    <= wr;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_shift <= '0;
                    end
                end
                S_REQ: begin
                    r_cnt <= '0;
                    r_tmo <= '0;
                end
                S_ADDR, S_WDATA: begin
                    r_tmo <= '0;
                    if (!bgrant || r_cnt == ((r_state == S_ADDR) ? A_LAST : D_LAST))
                        r_cnt <= '0;
                    else
                        r_cnt <= r_cnt + CW'(1);
                end
                S_RDATA: begin
                    if (!bgrant) begin
                        r_cnt <= '0;
                        r_tmo <= '0;
                    end else if (svalid) begin
                        r_shift <= {sin, r_shift[DATA_W-1:1]};
                        if (r_cnt == D_LAST) begin
                            r_rdata <= {sin, r_shift[DATA_W-1:1]};
                            r_err   <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end else if (r_cnt == '0) begin
                        // Idle watchdog only runs until the first sample lands.
                        if (r_tmo == T_LAST) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_tmo   <= '0;
                        end else begin
                            r_tmo <= r_tmo + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule
